inst_mem_ctrl: RTL

- Single-port access controller in front of the byte-wide instruction RAM (16-bit address, registered 1-cycle read, write enable active-high).
- Shares the RAM between the processor fetch unit (reads) and the program loader (sequential byte writes from 0).
- Sequences the registered-read latency and returns fetched bytes with a valid strobe.

---
 rtl/inst_mem_ctrl.sv | 172 +++++++++++++++++
 1 files changed

// File: rtl/inst_mem_ctrl.sv
// ---------------------------------------------------------------------------
// inst_mem_ctrl
// Single-port access controller for the byte-wide instruction RAM. The RAM is
// shared between the fetch unit (reads) and the program loader (sequential
// byte writes starting at address 0). The RAM has a registered 1-cycle read,
// so a granted fetch spends one cycle in RD before its byte is returned.
//
// Ports
//   clk_in, rst_n            clock (rising edge), async active-low reset
//   fetch_req / fetch_addr   fetch request and byte address (held until grant)
//   fetch_grant              combinational, request accepted this cycle
//   fetch_valid / fetch_data one-cycle strobe with fetched byte (data held)
//   load_start               pulse, start (or restart) a load session
//   load_valid / load_data   loader byte to write
//   load_end                 pulse, end the load session early
//   load_ready               combinational, high while in LOAD
//   load_done                one-cycle strobe after the session ends
//   load_count               bytes written in current/last session
//   mem_addr/mem_w/mem_din   RAM address, write enable, write data
//   mem_dout                 RAM registered read data
//
// State  | meaning
// -------+---------------------------------------------------------------
// IDLE   | no access in flight; arbitrates load (priority) vs. fetch
// RD     | RAM read issued last cycle; capture mem_dout this cycle
// LOAD   | loader owns the RAM; fetches stall
// ---------------------------------------------------------------------------
module inst_mem_ctrl #(
    parameter int ADDR_W     = 16,
    parameter int DATA_W     = 8,
    parameter int LOAD_LIMIT = 16
) (
    input  logic              clk_in,
    input  logic              rst_n,
    input  logic              fetch_req,
    input  logic [ADDR_W-1:0] fetch_addr,
    output logic              fetch_grant,
    output logic              fetch_valid,
    output logic [DATA_W-1:0] fetch_data,
    input  logic              load_start,
    input  logic              load_valid,
    input  logic [DATA_W-1:0] load_data,
    input  logic              load_end,
    output logic              load_ready,
    output logic              load_done,
    output logic [ADDR_W-1:0] load_count,
    output logic [ADDR_W-1:0] mem_addr,
    output logic              mem_w,
    output logic [DATA_W-1:0] mem_din,
    input  logic [DATA_W-1:0] mem_dout
);

    typedef enum logic [1:0] {
        ST_IDLE = 2'd0,
        ST_RD   = 2'd1,
        ST_LOAD = 2'd2
    } state_t;

    // Compared one bit wider so LOAD_LIMIT = 2^ADDR_W is still representable.
    localparam logic [ADDR_W:0] LAST_IDX = (ADDR_W + 1)'(LOAD_LIMIT - 1);

    state_t            state;
    state_t            state_nxt;
    logic [ADDR_W-1:0] rd_addr;
    logic              pend_load;

    logic              at_last;
    logic              cnt_clr;
    logic              cnt_inc;
    logic              pend_set;
    logic              pend_clr;
    logic              rd_done;
    logic              done_set;

    assign at_last = ({1'b0, load_count} == LAST_IDX);

    always_comb begin
        state_nxt   = state;
        fetch_grant = 1'b0;
        load_ready  = 1'b0;
        mem_addr    = '0;
        mem_w       = 1'b0;
        mem_din     = '0;
        cnt_clr     = 1'b0;
        cnt_inc     = 1'b0;
        pend_set    = 1'b0;
        pend_clr    = 1'b0;
        rd_done     = 1'b0;
        done_set    = 1'b0;

        case (state)
            ST_IDLE: begin
                if (load_start || pend_load) begin
                    state_nxt = ST_LOAD;
                    cnt_clr   = 1'b1;
                    pend_clr  = 1'b1;
                end else if (fetch_req) begin
                    fetch_grant = 1'b1;
                    mem_addr    = fetch_addr;
                    state_nxt   = ST_RD;
                end
            end

            ST_RD: begin
                // The read always completes; a load request is parked.
                mem_addr  = rd_addr;
                rd_done   = 1'b1;
                state_nxt = ST_IDLE;
                if (load_start) begin
                    pend_set = 1'b1;
                end
            end

            ST_LOAD: begin
                load_ready = 1'b1;
                if (load_valid) begin
                    mem_w    = 1'b1;
                    mem_addr = load_count;
                    mem_din  = load_data;
                end
                // Restart wins: a coincident write lands at the old address
                // but the counter goes back to zero.
                if (load_start) begin
                    cnt_clr = 1'b1;
                end else begin
                    cnt_inc = load_valid;
                    if ((load_valid && at_last) || load_end) begin
                        state_nxt = ST_IDLE;
                        done_set  = 1'b1;
                    end
                end
            end

            default: begin
                state_nxt = ST_IDLE;
            end
        endcase
    end

    always_ff @(posedge clk_in or negedge rst_n) begin
        if (!rst_n) begin
            state       <= ST_IDLE;
            rd_addr     <= '0;
            pend_load   <= 1'b0;
            fetch_valid <= 1'b0;
            fetch_data  <= '0;
            load_done   <= 1'b0;
            load_count  <= '0;
        end else begin
            state       <= state_nxt;
            fetch_valid <= rd_done;
            load_done   <= done_set;
            if (fetch_grant) begin
                rd_addr <= fetch_addr;
            end
            if (rd_done) begin
                fetch_data <= mem_dout;
            end
            if (pend_set) begin
                pend_load <= 1'b1;
            end else if (pend_clr) begin
                pend_load <= 1'b0;
            end
            if (cnt_clr) begin
                load_count <= '0;
            end else if (cnt_inc) begin
                load_count <= load_count + ADDR_W'(1);
            end
        end
    end

endmodule
